// File: rtl/missile_launch_sequencer_pkg.sv
// Shared definitions for the launch sequencer: FSM state encodings, default
// phase timings and small saturating/phase-length helpers.
package missile_launch_sequencer_pkg;

  typedef enum logic [2:0] {
    LS_IDLE     = 3'd0,
    LS_ARM      = 3'd1,
    LS_WAIT_ACK = 3'd2,
    LS_IGNITE   = 3'd3,
    LS_COOLDOWN = 3'd4,
    LS_FAULT    = 3'd5
  } ls_state_e;

  localparam int unsigned DEF_ARM_CYCLES      = 4;
  localparam int unsigned DEF_ACK_TIMEOUT     = 16;
  localparam int unsigned DEF_IGNITE_CYCLES   = 2;
  localparam int unsigned DEF_COOLDOWN_CYCLES = 8;

  // Phase timer width; every phase length must fit in 1..2**TIMER_W cycles.
  localparam int TIMER_W = 8;
  localparam int CNT_W   = 4;

  function automatic logic [CNT_W-1:0] satInc(input logic [CNT_W-1:0] v);
    return (v == {CNT_W{1'b1}}) ? v : v + 1'b1;
  endfunction

  // A phase of n cycles loads n-1 so that done rises in its final cycle.
  function automatic logic [TIMER_W-1:0] phaseLen(input int unsigned n);
    return (n > 0) ? TIMER_W'(n - 1) : '0;
  endfunction

endpackage

// File: rtl/missile_launch_sequencer_seq_timer.sv
// seq_timer: loadable down-counter that flags the last cycle of a phase.
// It stops at zero, so done stays high until the next load.
module missile_launch_sequencer_seq_timer #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load_i,
  input  logic [WIDTH-1:0] load_val_i,
  output logic             done_o
);

  logic [WIDTH-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = load_val_i;
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign done_o = (cnt_q == '0);

endmodule

// File: rtl/missile_launch_sequencer.sv
// Launch sequencer: arms the selected rail, waits for its ack, fires the
// ignite pulse, lets the rail settle, then steps to the next rail.
module missile_launch_sequencer
  import missile_launch_sequencer_pkg::*;
#(
  parameter int unsigned ARM_CYCLES      = DEF_ARM_CYCLES,
  parameter int unsigned ACK_TIMEOUT     = DEF_ACK_TIMEOUT,
  parameter int unsigned IGNITE_CYCLES   = DEF_IGNITE_CYCLES,
  parameter int unsigned COOLDOWN_CYCLES = DEF_COOLDOWN_CYCLES
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             launch_missile,
  input  logic             missile_ready_ack,
  input  logic             abort_command,
  output logic [2:0]       pylon_index,
  output logic             arm_pylon,
  output logic             ignite,
  output logic             seq_busy,
  output logic             fault,
  output logic [CNT_W-1:0] launches_completed,
  output logic [CNT_W-1:0] dropped_launches,
  output logic [2:0]       LS_state
);

  ls_state_e        state_q, state_d;
  logic             pending_q, pending_d;
  logic             ack_q;
  logic [2:0]       pylon_q, pylon_d;
  logic [CNT_W-1:0] launches_q, launches_d;
  logic [CNT_W-1:0] dropped_q, dropped_d;
  logic             arm_q, ignite_q, busy_q, fault_q;
  logic             drop;
  logic             timer_load, timer_done;
  logic [TIMER_W-1:0] timer_load_val;

  always_comb begin
    state_d    = state_q;
    pending_d  = pending_q;
    pylon_d    = pylon_q;
    launches_d = launches_q;
    dropped_d  = dropped_q;
    drop       = 1'b0;

    case (state_q)
      LS_IDLE: begin
        if (launch_missile) begin
          if (abort_command) begin
            drop = 1'b1;
          end else begin
            state_d = LS_ARM;
          end
        end
      end
      LS_ARM: begin
        if (timer_done) state_d = LS_WAIT_ACK;
      end
      LS_WAIT_ACK: begin
        if (ack_q) begin
          state_d = LS_IGNITE;
        end else if (timer_done) begin
          state_d = LS_FAULT;
        end
      end
      LS_IGNITE: begin
        if (timer_done) state_d = LS_COOLDOWN;
      end
      LS_COOLDOWN: begin
        if (timer_done) begin
          state_d = (pending_q || launch_missile) ? LS_ARM : LS_IDLE;
        end
      end
      LS_FAULT: begin
        if (launch_missile) drop = 1'b1;
      end
      default: state_d = LS_IDLE;
    endcase

    // Requests arriving mid-sequence queue one deep; any extra is discarded.
    if (launch_missile &&
        (state_q inside {LS_ARM, LS_WAIT_ACK, LS_IGNITE, LS_COOLDOWN})) begin
      if (pending_q) begin
        drop = 1'b1;
      end else begin
        pending_d = 1'b1;
      end
    end

    if (state_q == LS_COOLDOWN && state_d == LS_ARM) pending_d = 1'b0;

    if (abort_command && state_q != LS_IDLE) begin
      state_d   = LS_IDLE;
      pending_d = 1'b0;
      if (launch_missile) drop = 1'b1;
    end

    if (state_q == LS_IGNITE && state_d == LS_COOLDOWN) begin
      pylon_d    = pylon_q + 3'd1;
      launches_d = satInc(launches_q);
    end

    if (drop) dropped_d = satInc(dropped_q);
  end

  always_comb begin
    timer_load_val = '0;
    case (state_d)
      LS_ARM:      timer_load_val = phaseLen(ARM_CYCLES);
      LS_WAIT_ACK: timer_load_val = phaseLen(ACK_TIMEOUT);
      LS_IGNITE:   timer_load_val = phaseLen(IGNITE_CYCLES);
      LS_COOLDOWN: timer_load_val = phaseLen(COOLDOWN_CYCLES);
      default:     timer_load_val = '0;
    endcase
  end

  assign timer_load = (state_d != state_q);

  missile_launch_sequencer_seq_timer #(
    .WIDTH (TIMER_W)
  ) u_seq_timer (
    .clk        (clk),
    .rst        (rst),
    .load_i     (timer_load),
    .load_val_i (timer_load_val),
    .done_o     (timer_done)
  );

  // Strobes are registered from the next state so they line up with LS_state;
  // ack is only captured while waiting, which makes ARM blind to it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= LS_IDLE;
      pending_q  <= 1'b0;
      ack_q      <= 1'b0;
      pylon_q    <= '0;
      launches_q <= '0;
      dropped_q  <= '0;
      arm_q      <= 1'b0;
      ignite_q   <= 1'b0;
      busy_q     <= 1'b0;
      fault_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      pending_q  <= pending_d;
      ack_q      <= missile_ready_ack && (state_q == LS_WAIT_ACK);
      pylon_q    <= pylon_d;
      launches_q <= launches_d;
      dropped_q  <= dropped_d;
      arm_q      <= state_d inside {LS_ARM, LS_WAIT_ACK, LS_IGNITE};
      ignite_q   <= (state_d == LS_IGNITE);
      busy_q     <= (state_d != LS_IDLE);
      fault_q    <= (state_d == LS_FAULT);
    end
  end

  assign pylon_index        = pylon_q;
  assign arm_pylon          = arm_q;
  assign ignite             = ignite_q;
  assign seq_busy           = busy_q;
  assign fault              = fault_q;
  assign launches_completed = launches_q;
  assign dropped_launches   = dropped_q;
  assign LS_state           = state_q;

endmodule

// File: tb/tb_missile_launch_sequencer.sv
// Directed bench for the launch sequencer: expectations are queued as stimulus
// is applied and popped against DUT outputs sampled 1 ns after each edge.
`timescale 1ns/1ps
module tb_missile_launch_sequencer;
  import missile_launch_sequencer_pkg::*;

  logic       clk, rst, launch, ack, abort;
  logic [2:0] pylonIndex, lsState;
  logic       armPylon, igniteOut, seqBusy, faultOut;
  logic [3:0] launchesCompleted, droppedLaunches;

  int testsRun = 0;
  int failCount = 0;
  int unsigned expLaunches = 0, expPylon = 0, expDropped = 0;

  typedef struct {
    string       tag;
    int unsigned val;
  } expEntry_t;
  expEntry_t expQ[$];

  missile_launch_sequencer dut (
    .clk                (clk),
    .rst                (rst),
    .launch_missile     (launch),
    .missile_ready_ack  (ack),
    .abort_command      (abort),
    .pylon_index        (pylonIndex),
    .arm_pylon          (armPylon),
    .ignite             (igniteOut),
    .seq_busy           (seqBusy),
    .fault              (faultOut),
    .launches_completed (launchesCompleted),
    .dropped_launches   (droppedLaunches),
    .LS_state           (lsState)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick(input int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic l, input logic a, input logic ab);
    launch = l;
    ack    = a;
    abort  = ab;
  endtask

  task automatic expectVal(input string tag, input int unsigned val);
    expEntry_t e;
    e.tag = tag;
    e.val = val;
    expQ.push_back(e);
  endtask

  task automatic checkOutput(input int unsigned obs);
    expEntry_t e;
    testsRun++;
    if (expQ.size() == 0) begin
      failCount++;
      $error("FAIL scoreboard_empty: observed %0d with nothing expected", obs);
    end else begin
      e = expQ.pop_front();
      assert (obs === e.val) else begin
        failCount++;
        $error("FAIL %s: observed %0d expected %0d", e.tag, obs, e.val);
      end
    end
  endtask

  task automatic expectCounters(input string pfx);
    expectVal({pfx, "_pylon"}, expPylon);
    expectVal({pfx, "_launches"}, expLaunches);
    expectVal({pfx, "_dropped"}, expDropped);
  endtask

  task automatic checkCounters();
    checkOutput(pylonIndex);
    checkOutput(launchesCompleted);
    checkOutput(droppedLaunches);
  endtask

  // One complete uninterrupted sequence from IDLE back to IDLE.
  task automatic fullLaunch();
    applyStimulus(1, 0, 0); tick();
    applyStimulus(0, 0, 0); tick(4);
    applyStimulus(0, 1, 0); tick();
    applyStimulus(0, 0, 0); tick(3);
    tick(8);
    expPylon    = (expPylon + 1) % 8;
    expLaunches = (expLaunches < 15) ? expLaunches + 1 : 15;
  endtask

  initial begin
    rst = 1'b1;
    applyStimulus(0, 0, 0);
    tick(3);
    expectVal("rst_state", LS_IDLE); expectVal("rst_arm", 0);
    expectVal("rst_ignite", 0); expectVal("rst_busy", 0); expectVal("rst_fault", 0);
    expectCounters("rst");
    checkOutput(lsState); checkOutput(armPylon); checkOutput(igniteOut);
    checkOutput(seqBusy); checkOutput(faultOut); checkCounters();
    rst = 1'b0;
    tick(2);

    // Nominal: launch, ack in the second WAIT_ACK cycle, ignite, cooldown.
    applyStimulus(1, 0, 0); tick();
    applyStimulus(0, 0, 0);
    expectVal("nom_arm_state", LS_ARM); expectVal("nom_arm_strobe", 1);
    expectVal("nom_arm_busy", 1); expectVal("nom_arm_ignite", 0);
    checkOutput(lsState); checkOutput(armPylon); checkOutput(seqBusy); checkOutput(igniteOut);
    tick(3);
    expectVal("nom_arm_last", LS_ARM); checkOutput(lsState);
    tick();
    expectVal("nom_wait_state", LS_WAIT_ACK); expectVal("nom_wait_arm", 1);
    checkOutput(lsState); checkOutput(armPylon);
    tick();
    applyStimulus(0, 1, 0); tick();
    applyStimulus(0, 0, 0);
    expectVal("nom_ack_latency", LS_WAIT_ACK); checkOutput(lsState);
    tick();
    expectVal("nom_ign_state", LS_IGNITE); expectVal("nom_ign1", 1); expectVal("nom_ign_arm", 1);
    checkOutput(lsState); checkOutput(igniteOut); checkOutput(armPylon);
    tick();
    expectVal("nom_ign2", 1); checkOutput(igniteOut);
    tick();
    expPylon = 1; expLaunches = 1;
    expectVal("nom_cd_state", LS_COOLDOWN); expectVal("nom_cd_ignite", 0);
    expectVal("nom_cd_arm", 0); expectCounters("nom_cd");
    checkOutput(lsState); checkOutput(igniteOut); checkOutput(armPylon); checkCounters();
    tick(7);
    expectVal("nom_cd_last", LS_COOLDOWN); checkOutput(lsState);
    tick();
    expectVal("nom_idle_state", LS_IDLE); expectVal("nom_idle_busy", 0);
    checkOutput(lsState); checkOutput(seqBusy);

    // Ack held through ARM must not be acted on.
    applyStimulus(1, 0, 0); tick();
    applyStimulus(0, 1, 0); tick(4);
    applyStimulus(0, 0, 0); tick();
    expectVal("armack_ignored", LS_WAIT_ACK); checkOutput(lsState);
    applyStimulus(0, 0, 1); tick();
    applyStimulus(0, 0, 0);
    expectVal("armack_abort_idle", LS_IDLE); checkOutput(lsState);

    // Timeout: 4 ARM + 16 WAIT_ACK cycles, then FAULT.
    applyStimulus(1, 0, 0); tick();
    applyStimulus(0, 0, 0); tick(19);
    expectVal("to_last_wait", LS_WAIT_ACK); checkOutput(lsState);
    tick();
    expectVal("to_fault_state", LS_FAULT); expectVal("to_fault_flag", 1);
    expectVal("to_fault_arm", 0); expectVal("to_fault_busy", 1);
    checkOutput(lsState); checkOutput(faultOut); checkOutput(armPylon); checkOutput(seqBusy);
    applyStimulus(1, 0, 0); tick();
    applyStimulus(0, 0, 0);
    expDropped = 1;
    expectVal("to_fault_hold", LS_FAULT); expectCounters("to_drop");
    checkOutput(lsState); checkCounters();
    applyStimulus(0, 0, 1); tick();
    applyStimulus(0, 0, 0);
    expectVal("to_abort_idle", LS_IDLE); expectVal("to_abort_fault", 0);
    checkOutput(lsState); checkOutput(faultOut);

    // Queueing: three requests in one sequence -> one pending, one dropped.
    applyStimulus(1, 0, 0); tick();
    applyStimulus(0, 0, 0); tick();
    applyStimulus(1, 0, 0); tick();
    applyStimulus(0, 0, 0); tick();
    applyStimulus(1, 0, 0); tick();
    applyStimulus(0, 0, 0);
    expDropped = 2;
    expectVal("q_wait", LS_WAIT_ACK); expectCounters("q_third");
    checkOutput(lsState); checkCounters();
    applyStimulus(0, 1, 0); tick();
    applyStimulus(0, 0, 0); tick(3);
    tick(7);
    expectVal("q_cd_last", LS_COOLDOWN); checkOutput(lsState);
    tick();
    expectVal("q_rearm_no_idle", LS_ARM); expectVal("q_rearm_busy", 1);
    checkOutput(lsState); checkOutput(seqBusy);
    tick(4);
    applyStimulus(0, 1, 0); tick();
    applyStimulus(0, 0, 0); tick(3);
    tick(8);
    expPylon = 3; expLaunches = 3;
    expectVal("q_final_idle", LS_IDLE); expectCounters("q_final");
    checkOutput(lsState); checkCounters();

    // Abort during IGNITE keeps counters and rail.
    applyStimulus(1, 0, 0); tick();
    applyStimulus(0, 0, 0); tick(4);
    applyStimulus(0, 1, 0); tick();
    applyStimulus(0, 0, 0); tick();
    expectVal("abi_ignite_on", 1); checkOutput(igniteOut);
    applyStimulus(0, 0, 1); tick();
    applyStimulus(0, 0, 0);
    expectVal("abi_state", LS_IDLE); expectVal("abi_ignite_off", 0);
    expectVal("abi_arm_off", 0); expectCounters("abi");
    checkOutput(lsState); checkOutput(igniteOut); checkOutput(armPylon); checkCounters();

    // Abort and launch together in WAIT_ACK with a request already pending.
    applyStimulus(1, 0, 0); tick(2);
    applyStimulus(0, 0, 0); tick(3);
    expectVal("al_wait", LS_WAIT_ACK); checkOutput(lsState);
    applyStimulus(1, 0, 1); tick();
    applyStimulus(0, 0, 0);
    expDropped = 3;
    expectVal("al_idle", LS_IDLE); expectCounters("al");
    checkOutput(lsState); checkCounters();
    fullLaunch();
    expectVal("al_pending_cleared", LS_IDLE); expectCounters("al_after");
    checkOutput(lsState); checkCounters();

    // Reset mid-ARM clears outputs without a clock edge.
    applyStimulus(1, 0, 0); tick();
    applyStimulus(0, 0, 0); tick();
    expectVal("rm_arm_before", 1); checkOutput(armPylon);
    rst = 1'b1;
    #1;
    expPylon = 0; expLaunches = 0; expDropped = 0;
    expectVal("rm_state", LS_IDLE); expectVal("rm_arm", 0);
    expectVal("rm_busy", 0); expectCounters("rm");
    checkOutput(lsState); checkOutput(armPylon); checkOutput(seqBusy); checkCounters();
    @(posedge clk); #1;
    rst = 1'b0;
    tick();

    // Rail wrap and launch-count saturation over 17 launches.
    for (int k = 1; k <= 17; k++) begin
      fullLaunch();
      expectVal("wrap_idle", LS_IDLE); expectCounters($sformatf("wrap%0d", k));
      checkOutput(lsState); checkCounters();
    end

    if (expQ.size() != 0) begin
      failCount++;
      $display("[TB] FAIL scoreboard_leftover: observed %0d entries expected 0", expQ.size());
    end
    $display("[TB] %0d tests run, %0d failed", testsRun, failCount);
    $finish;
  end

endmodule
